// File: rtl/bus_fifo_pkt.sv
// Packet-aware word FIFO for the readout bus: inferred RAM, optional show-ahead
// output, fill level, almost-full, complete-packet count and sticky error flags.
module bus_fifo_pkt #(
  parameter int W            = 32,
  parameter int DEPTH_LOG2   = 7,
  parameter int AFULL_MARGIN = 4,
  parameter int SHOWAHEAD    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [W-1:0]          data_i,
  input  logic                  pktend_i,
  input  logic                  we_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  re_i,
  output logic [W-1:0]          data_o,
  output logic                  pktend_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DEPTH_LOG2:0]   pkt_count_o,
  output logic                  pkt_avail_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LIM = CW'(DEPTH - AFULL_MARGIN);

  logic [W:0]            mem [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [CW-1:0]         wptr, rptr, ram_lvl;
  logic [CW-1:0]         cnt_nxt, pkt_nxt;
  logic                  wr_acc, rd_acc, fetch, rd_pend;

  assign wr_acc  = we_i & ~full_o;
  assign rd_acc  = re_i & ~empty_o;
  assign ram_lvl = wptr - rptr;

  // Show-ahead keeps the output register loaded whenever the RAM holds a word
  // written on an earlier cycle; normal mode only reads on request.
  assign fetch = (SHOWAHEAD != 0) ? ((ram_lvl != '0) & (empty_o | rd_acc)) : rd_acc;

  // Packet end of the word being popped: output register in show-ahead,
  // otherwise a flag shadow kept beside the RAM so the RAM stays sync-read.
  assign rd_pend = (SHOWAHEAD != 0) ? pktend_o : pend_q[rptr[DEPTH_LOG2-1:0]];

  assign pkt_avail_o = (pkt_count_o != '0);

  always_comb begin
    cnt_nxt = count_o;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = count_o + CW'(1);
      2'b01:   cnt_nxt = count_o - CW'(1);
      default: cnt_nxt = count_o;
    endcase
    pkt_nxt = pkt_count_o;
    case ({wr_acc & pktend_i, rd_acc & rd_pend})
      2'b10:   pkt_nxt = pkt_count_o + CW'(1);
      2'b01:   pkt_nxt = pkt_count_o - CW'(1);
      default: pkt_nxt = pkt_count_o;
    endcase
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wptr[DEPTH_LOG2-1:0]]    <= {pktend_i, data_i};
      pend_q[wptr[DEPTH_LOG2-1:0]] <= pktend_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count_o     <= '0;
      pkt_count_o <= '0;
      empty_o     <= 1'b1;
      full_o      <= 1'b0;
      afull_o     <= 1'b0;
      ovf_o       <= 1'b0;
      udf_o       <= 1'b0;
      data_o      <= '0;
      pktend_o    <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + CW'(1);
      if (fetch) begin
        rptr               <= rptr + CW'(1);
        {pktend_o, data_o} <= mem[rptr[DEPTH_LOG2-1:0]];
      end
      count_o     <= cnt_nxt;
      pkt_count_o <= pkt_nxt;
      full_o      <= (cnt_nxt == DEPTH_C);
      afull_o     <= (cnt_nxt >= AFULL_LIM);
      if (SHOWAHEAD != 0)
        empty_o <= ~(fetch | (~empty_o & ~rd_acc));
      else
        empty_o <= (cnt_nxt == '0);
      ovf_o <= ovf_o | (we_i & full_o);
      udf_o <= udf_o | (re_i & empty_o);
    end
  end
endmodule

// File: tb/tb_bus_fifo_pkt.sv
// Bench for bus_fifo_pkt: three configurations driven side by side and compared
// every cycle against a queue-level model of the FIFO rules.
module tb_bus_fifo_pkt;
  localparam int N = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  we, re, pe;
  logic [31:0] din [3];

  logic [2:0]  full, afull, empty, pav, ovf, udf, pko;
  logic [31:0] do0, do1;
  logic [15:0] do2;
  logic [7:0]  cnt0, cnt1, pc0, pc1;
  logic [4:0]  cnt2, pc2;

  bus_fifo_pkt #(.W(32), .DEPTH_LOG2(7), .AFULL_MARGIN(4), .SHOWAHEAD(0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_i(din[0]), .pktend_i(pe[0]), .we_i(we[0]),
    .full_o(full[0]), .afull_o(afull[0]), .re_i(re[0]), .data_o(do0), .pktend_o(pko[0]),
    .empty_o(empty[0]), .count_o(cnt0), .pkt_count_o(pc0), .pkt_avail_o(pav[0]),
    .ovf_o(ovf[0]), .udf_o(udf[0]));

  bus_fifo_pkt #(.W(32), .DEPTH_LOG2(7), .AFULL_MARGIN(4), .SHOWAHEAD(1)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[1]), .pktend_i(pe[1]), .we_i(we[1]),
    .full_o(full[1]), .afull_o(afull[1]), .re_i(re[1]), .data_o(do1), .pktend_o(pko[1]),
    .empty_o(empty[1]), .count_o(cnt1), .pkt_count_o(pc1), .pkt_avail_o(pav[1]),
    .ovf_o(ovf[1]), .udf_o(udf[1]));

  bus_fifo_pkt #(.W(16), .DEPTH_LOG2(4), .AFULL_MARGIN(2), .SHOWAHEAD(0)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(din[2][15:0]), .pktend_i(pe[2]), .we_i(we[2]),
    .full_o(full[2]), .afull_o(afull[2]), .re_i(re[2]), .data_o(do2), .pktend_o(pko[2]),
    .empty_o(empty[2]), .count_o(cnt2), .pkt_count_o(pc2), .pkt_avail_o(pav[2]),
    .ovf_o(ovf[2]), .udf_o(udf[2]));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a word queue with write timestamps, per configuration.
  int          c_depth [3] = '{128, 128, 16};
  int          c_marg  [3] = '{4, 4, 2};
  int          c_sa    [3] = '{0, 1, 0};
  logic [31:0] c_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mq [3][N];
  logic        mp [3][N];
  int          ms [3][N];
  int          hd [3], tl [3];
  logic        m_ovf [3], m_udf [3], m_vis [3], m_po [3];
  logic [31:0] m_do [3];

  task automatic model_edge(input int k);
    int  sz;
    bit  fl, em, wa, ra;
    if (rst) begin
      hd[k] = 0; tl[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      m_vis[k] = 0; m_do[k] = '0; m_po[k] = 0;
      return;
    end
    sz = tl[k] - hd[k];
    fl = (sz == c_depth[k]);
    em = (c_sa[k] != 0) ? !m_vis[k] : (sz == 0);
    wa = we[k] && !fl;
    ra = re[k] && !em;
    if (we[k] && fl) m_ovf[k] = 1;
    if (re[k] && em) m_udf[k] = 1;
    if (ra) begin
      if (c_sa[k] == 0) begin
        m_do[k] = mq[k][hd[k] % N];
        m_po[k] = mp[k][hd[k] % N];
      end
      hd[k]++;
    end
    if (wa) begin
      mq[k][tl[k] % N] = din[k] & c_mask[k];
      mp[k][tl[k] % N] = pe[k];
      ms[k][tl[k] % N] = cyc;
      tl[k]++;
    end
    // Show-ahead: the head is visible once it was written before this edge.
    if (c_sa[k] != 0) begin
      m_vis[k] = (tl[k] > hd[k]) && (ms[k][hd[k] % N] < cyc);
      if (m_vis[k]) begin
        m_do[k] = mq[k][hd[k] % N];
        m_po[k] = mp[k][hd[k] % N];
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc%0d: got %0h expected %0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    int          sz, pk;
    logic [63:0] o_cnt, o_pc, o_do;
    sz = tl[k] - hd[k];
    pk = 0;
    for (int i = hd[k]; i < tl[k]; i++) if (mp[k][i % N]) pk++;
    case (k)
      0:       begin o_cnt = 64'(cnt0); o_pc = 64'(pc0); o_do = 64'(do0); end
      1:       begin o_cnt = 64'(cnt1); o_pc = 64'(pc1); o_do = 64'(do1); end
      default: begin o_cnt = 64'(cnt2); o_pc = 64'(pc2); o_do = 64'(do2); end
    endcase
    chk("count",  k, o_cnt, 64'(sz));
    chk("pktcnt", k, o_pc,  64'(pk));
    chk("pkavl",  k, 64'(pav[k]),   64'(pk != 0));
    chk("full",   k, 64'(full[k]),  64'(sz == c_depth[k]));
    chk("afull",  k, 64'(afull[k]), 64'((c_depth[k] - sz) <= c_marg[k]));
    chk("empty",  k, 64'(empty[k]), 64'((c_sa[k] != 0) ? !m_vis[k] : (sz == 0)));
    chk("ovf",    k, 64'(ovf[k]),   64'(m_ovf[k]));
    chk("udf",    k, 64'(udf[k]),   64'(m_udf[k]));
    chk("data",   k, o_do,          64'(m_do[k]));
    chk("pktend", k, 64'(pko[k]),   64'(m_po[k]));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic idle();
    we = '0; re = '0; pe = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) din[k] = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Fill all: 128 words with pktend every 16th; small config fills at 16.
    for (int i = 0; i < 128; i++) begin
      we = 3'b011;
      we[2] = (i < 16);
      din[0] = i; din[1] = i; din[2] = 32'h100 + i;
      pe[0] = (i % 16 == 15); pe[1] = pe[0]; pe[2] = (i % 4 == 3);
      step();
    end
    // Write while full.
    we = 3'b111; pe = '0;
    din[0] = 32'hDEAD; din[1] = 32'hDEAD; din[2] = 32'hDEAD;
    step();
    idle();
    step();
    step();
    // Drain everything.
    for (int i = 0; i < 128; i++) begin
      re = 3'b011;
      re[2] = (i < 16);
      step();
    end
    idle();
    step();

    // Fresh start, then a single packet into the show-ahead FIFO.
    rst = 1'b1; step(); rst = 1'b0;
    we = 3'b010; din[1] = 32'hA5A5_A5A5; pe = 3'b010;
    step();
    idle();
    repeat (3) step();
    re = 3'b010; step(); idle(); step();

    // Stand at 10 words, then read and write every cycle across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      we = 3'b011; din[0] = $urandom; din[1] = $urandom; pe = 3'(($urandom % 2) * 3);
      step();
    end
    idle();
    repeat (2) step();
    for (int i = 0; i < 300; i++) begin
      we = 3'b011; re = 3'b011;
      din[0] = $urandom; din[1] = $urandom; pe = 3'($urandom % 4);
      step();
    end
    idle();
    step();

    // Underflow: drain the normal FIFO and keep reading.
    re = 3'b001;
    repeat (13) step();
    idle();
    step();

    // Reset with 50 words held; the first new word must come out first.
    for (int i = 0; i < 50; i++) begin
      we = 3'b011; din[0] = 32'h5000 + i; din[1] = 32'h6000 + i; pe = 3'(i % 4);
      step();
    end
    idle();
    rst = 1'b1; step(); rst = 1'b0;
    we = 3'b011; din[0] = 32'h1234; din[1] = 32'h4321; pe = 3'b011;
    step();
    idle(); step(); step();
    re = 3'b011; step(); idle(); step();

    // Random traffic, write-heavy then read-heavy, on all three.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        we[k] = ($urandom_range(0, 99) < ((i < 300) ? 70 : 35));
        re[k] = ($urandom_range(0, 99) < ((i < 300) ? 35 : 70));
        pe[k] = ($urandom_range(0, 3) == 0);
        din[k] = $urandom;
      end
      if (i == 450) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_fifo_pkt.md
Name: bus_fifo_pkt

Overview:
- Parametrised successor of the 33-bit packet FIFO used on the readout bus.
- Stores W-bit data words, each with a packet-end flag, in inferred on-chip RAM. Written by a producer (event builder), drained by the USB/bus output stage.
- Adds over the previous generation:
  - selectable show-ahead mode;
  - fill level and almost-full threshold;
  - a count of complete packets stored, so the consumer starts reading only when a whole packet is available;
  - sticky overflow/underflow flags instead of unchecked behaviour.

Parameters:
- W, 32: data width in bits, excluding the pktend flag.
- DEPTH_LOG2, 7: storage depth is 2^DEPTH_LOG2 words (default 128).
- AFULL_MARGIN, 4: afull_o asserts when free space <= AFULL_MARGIN; legal range 1..2^DEPTH_LOG2-1.
- SHOWAHEAD, 0: 0 = normal read (data one cycle after re_i); 1 = first-word-fall-through.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- data_i  in  W  write data
- pktend_i  in  1  write word is the last word of a packet
- we_i  in  1  write request
- full_o  out  1  no free space
- afull_o  out  1  free space <= AFULL_MARGIN
- re_i  in  1  read request
- data_o  out  W  read data
- pktend_o  out  1  pktend flag of the read word
- empty_o  out  1  no word readable
- count_o  out  DEPTH_LOG2+1  words held, including any prefetched word
- pkt_count_o  out  DEPTH_LOG2+1  complete packets held (words with pktend=1 not yet read)
- pkt_avail_o  out  1  pkt_count_o != 0
- ovf_o  out  1  sticky: write attempted while full
- udf_o  out  1  sticky: read attempted while empty

Behaviour:
- Clocking and reset:
  - Single clock domain, clk_i. Reset rst_i is synchronous and active-high.
  - While rst_i is high, all of the following hold: pointers = 0, count_o = 0, pkt_count_o = 0, empty_o = 1, full_o = 0, afull_o = 0, pkt_avail_o = 0, ovf_o = 0, udf_o = 0, data_o = 0, pktend_o = 0.
  - RAM contents are not cleared. Reset mid-operation discards all stored words and packets; the first accepted write after reset is word 0.
- Accepted write: we_i & !full_o. The word {pktend_i, data_i} is stored at the write pointer and the pointer increments, wrapping modulo 2^DEPTH_LOG2.
- Write while full: the word is dropped, ovf_o is set, and pointers and counts are unchanged. This holds even if re_i is accepted in the same cycle.
- Accepted read: re_i & !empty_o.
- Read while empty: ignored, udf_o is set, data_o holds its value.
- SHOWAHEAD=0:
  - empty_o = (count_o == 0). It falls one cycle after the first accepted write.
  - After an accepted read, data_o/pktend_o present the word on the next cycle and hold until the next accepted read.
- SHOWAHEAD=1:
  - data_o/pktend_o present the head word whenever empty_o = 0. An accepted read pops that word and the next head appears the following cycle; back-to-back reads sustain 1 word/cycle.
  - Write-to-empty_o-low latency is 2 cycles: RAM read plus output register.
  - count_o includes the prefetched word.
- count_o:
  - +1 on an accepted write only, -1 on an accepted read only, unchanged when both happen.
  - Range 0..2^DEPTH_LOG2.
  - full_o = (count_o == 2^DEPTH_LOG2).
  - afull_o = (2^DEPTH_LOG2 - count_o <= AFULL_MARGIN).
  - Flags are registered and consistent with count_o in the same cycle.
- pkt_count_o:
  - +1 on an accepted write with pktend_i = 1.
  - -1 on an accepted read of a word whose stored pktend = 1.
  - Both in the same cycle give no change.
  - It never exceeds count_o.
- Simultaneous read and write when count_o = 0 (SHOWAHEAD=0): the read is rejected as underflow and the write is accepted. The RAM has no read-during-write bypass.
- ovf_o/udf_o clear only on rst_i.

Test Plan:
- Reset, then write 128 words 0x0..0x7F with pktend on every 16th word -> full_o = 1 after the 128th write, count_o = 128, pkt_count_o = 8, afull_o = 1 from count_o = 124.
- 129th write while full (data 0xDEAD) -> ovf_o = 1, count unchanged. Drain all 128 words -> sequence 0x0..0x7F, pktend_o on 0xF, 0x1F, ..., 0x7F; empty_o = 1 at the end, pkt_count_o = 0.
- SHOWAHEAD=1, write 0xA5A5A5A5 with pktend=1 -> empty_o low 2 cycles later, data_o = 0xA5A5A5A5, pkt_avail_o = 1 without asserting re_i.
- Continuous we_i and re_i at count_o = 10 for 300 cycles (pointer wrap) -> count_o stays 10, data in order, no ovf_o/udf_o.
- re_i while empty -> udf_o = 1, data_o unchanged. rst_i pulse mid-stream with count_o = 50 -> all outputs return to reset values next cycle, and the next written word is read first.
- W=16, DEPTH_LOG2=4, AFULL_MARGIN=2 -> full at 16 words, afull_o at 14 words.
